// File: rtl/datapath_regbank_pkg.sv
// Shared definitions for the counting register bank: count-operation
// encodings and the helper that derives an index width from a register count.
package datapath_regbank_pkg;

    localparam logic [1:0] IDOP_HOLD = 2'b00;
    localparam logic [1:0] IDOP_INC  = 2'b01;
    localparam logic [1:0] IDOP_DEC  = 2'b10;

    // Bits needed to index n registers (never less than 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : datapath_regbank_pkg

// File: rtl/datapath_regbank_idreg_cell.sv
// One WIDTH-bit register with load and increment/decrement. carry_in and
// borrow_in gate the count so two cells can be chained into a double-width
// counter; carry_out/borrow_out flag that this cell's count wraps.
module idreg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             borrow_out
);

    logic [WIDTH-1:0] r_q;
    logic             w_inc_en;
    logic             w_dec_en;

    assign w_inc_en   = inc & carry_in;
    assign w_dec_en   = dec & borrow_in;

    // Wrap flags come from the current value and the requested count only,
    // so a load on this cell does not stop the carry reaching its partner.
    assign carry_out  = w_inc_en & (&r_q);
    assign borrow_out = w_dec_en & ~(|r_q);
    assign q          = r_q;

    // Register update: load has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (w_inc_en) begin
            r_q <= r_q + 1'b1;
        end else if (w_dec_en) begin
            r_q <= r_q - 1'b1;
        end
    end

endmodule : idreg_cell

// File: rtl/datapath_regbank.sv
// Bank of NREGS count-capable registers with two OR-merged read buses,
// optional pairing of adjacent registers into double-width counters,
// a registered wrap pulse and a sticky bus-contention flag.
module datapath_regbank
    import datapath_regbank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [IDXW-1:0]  ld_sel,
    input  logic             ld_src,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] mem_in,
    input  logic [1:0]       idop,
    input  logic [IDXW-1:0]  id_sel,
    input  logic             pair_mode,
    input  logic [NREGS-1:0] drv_d,
    input  logic [NREGS-1:0] drv_m,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] mem_out,
    output logic             wrap,
    output logic             contention
);

    // Comparison width wide enough to hold both any index and NREGS itself.
    localparam int SELW = (IDXW > idx_width(NREGS)) ? IDXW : idx_width(NREGS);
    localparam int CW   = SELW + 1;

    logic [NREGS-1:0][WIDTH-1:0] w_q;
    logic [NREGS-1:0]            w_ld;
    logic [NREGS-1:0]            w_hit;
    logic [NREGS-1:0]            w_inc;
    logic [NREGS-1:0]            w_dec;
    logic [NREGS-1:0]            w_cin;
    logic [NREGS-1:0]            w_bin;
    logic [NREGS-1:0]            w_cout;
    logic [NREGS-1:0]            w_bout;
    logic [WIDTH-1:0]            w_ld_val;
    logic                        w_ld_ok;
    logic                        w_cnt_ok;
    logic                        w_ld_on_target;
    logic                        w_wrap_hit;
    logic                        w_wrap_next;
    logic                        w_multi;
    logic                        r_wrap;
    logic                        r_contention;

    // Out-of-range indices are simply dropped.
    assign w_ld_ok  = ld && (CW'(ld_sel) < CW'(NREGS));
    assign w_cnt_ok = ((idop == IDOP_INC) || (idop == IDOP_DEC)) &&
                      (CW'(id_sel) < CW'(NREGS));
    assign w_ld_val = ld_src ? mem_in : data_in;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        assign w_ld[i]  = w_ld_ok && (ld_sel == IDXW'(i));
        assign w_hit[i] = w_cnt_ok &&
                          (pair_mode ? ((id_sel >> 1) == IDXW'(i / 2))
                                     : (id_sel == IDXW'(i)));
        assign w_inc[i] = w_hit[i] && (idop == IDOP_INC);
        assign w_dec[i] = w_hit[i] && (idop == IDOP_DEC);

        // Odd cells take their count enable from the even cell below when paired.
        if ((i % 2) == 1) begin : g_hi
            assign w_cin[i] = pair_mode ? w_cout[i-1] : 1'b1;
            assign w_bin[i] = pair_mode ? w_bout[i-1] : 1'b1;
        end else begin : g_lo
            assign w_cin[i] = 1'b1;
            assign w_bin[i] = 1'b1;
        end

        idreg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .ld         (w_ld[i]),
            .ld_val     (w_ld_val),
            .inc        (w_inc[i]),
            .dec        (w_dec[i]),
            .carry_in   (w_cin[i]),
            .borrow_in  (w_bin[i]),
            .q          (w_q[i]),
            .carry_out  (w_cout[i]),
            .borrow_out (w_bout[i])
        );
    end

    // A load landing anywhere in the counted target cancels its wrap.
    assign w_ld_on_target = w_ld_ok &&
                            (pair_mode ? ((ld_sel >> 1) == (id_sel >> 1))
                                       : (ld_sel == id_sel));

    // Wrap of the whole target: the top cell of a pair, or the single cell.
    always_comb begin
        w_wrap_hit = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (!pair_mode || ((i % 2) == 1)) begin
                w_wrap_hit = w_wrap_hit | w_cout[i] | w_bout[i];
            end
        end
    end

    assign w_wrap_next = w_wrap_hit && !w_ld_on_target;

    // Read buses: OR of every register whose drive enable is set.
    always_comb begin
        data_out = '0;
        mem_out  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (drv_d[i]) begin
                data_out = data_out | w_q[i];
            end
            if (drv_m[i]) begin
                mem_out = mem_out | w_q[i];
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi = ((drv_d & (drv_d - 1'b1)) != '0) ||
                     ((drv_m & (drv_m - 1'b1)) != '0);

    // Wrap pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    // Sticky contention flag; a fresh contention beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention <= 1'b0;
        end else if (w_multi) begin
            r_contention <= 1'b1;
        end else if (clr_err) begin
            r_contention <= 1'b0;
        end
    end

    assign wrap       = r_wrap;
    assign contention = r_contention;

endmodule : datapath_regbank

// File: tb/tb_datapath_regbank.sv
// Directed bench for datapath_regbank with hand-computed expectations.
module tb_datapath_regbank;
    import datapath_regbank_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst_n;
    logic             ld;
    logic [IDXW-1:0]  ld_sel;
    logic             ld_src;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] mem_in;
    logic [1:0]       idop;
    logic [IDXW-1:0]  id_sel;
    logic             pair_mode;
    logic [NREGS-1:0] drv_d;
    logic [NREGS-1:0] drv_m;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] mem_out;
    logic             wrap;
    logic             contention;

    int n_chk;
    int n_err;

    datapath_regbank #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .IDXW  (IDXW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld),
        .ld_sel     (ld_sel),
        .ld_src     (ld_src),
        .data_in    (data_in),
        .mem_in     (mem_in),
        .idop       (idop),
        .id_sel     (id_sel),
        .pair_mode  (pair_mode),
        .drv_d      (drv_d),
        .drv_m      (drv_m),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .mem_out    (mem_out),
        .wrap       (wrap),
        .contention (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read one register through the data bus and compare.
    task automatic chk_reg(input string tag, input int idx, input logic [WIDTH-1:0] exp);
        drv_d      = '0;
        drv_d[idx] = 1'b1;
        #1;
        chk(tag, 32'(data_out), 32'(exp));
        drv_d = '0;
    endtask

    task automatic load(input int idx, input logic [WIDTH-1:0] val);
        ld      = 1'b1;
        ld_sel  = IDXW'(idx);
        ld_src  = 1'b0;
        data_in = val;
        step();
        ld = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0; ld = 1'b0; ld_sel = '0; ld_src = 1'b0;
        data_in = '0; mem_in = '0; idop = IDOP_HOLD; id_sel = '0;
        pair_mode = 1'b0; drv_d = '1; drv_m = '1; clr_err = 1'b0;

        // Reset state, buses stay live during reset
        #3;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_mem_out", 32'(mem_out), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_contention", 32'(contention), 32'h0);
        drv_d = '0; drv_m = '0;
        #9;
        rst_n = 1'b1;
        step();

        // Load reg2 from data_in, read on data bus
        load(2, 8'h5A);
        drv_d = 8'h04;
        #1;
        chk("ld_data_out", 32'(data_out), 32'h5A);
        chk("ld_mem_out", 32'(mem_out), 32'h00);
        step();
        chk("ld_contention", 32'(contention), 32'h0);
        drv_d = '0;

        // Pair increment with carry, no wrap
        load(0, 8'hFF);
        load(1, 8'h12);
        pair_mode = 1'b1; id_sel = 3'd0; idop = IDOP_INC;
        step();
        idop = IDOP_HOLD; pair_mode = 1'b0;
        chk("pinc_wrap", 32'(wrap), 32'h0);
        chk_reg("pinc_r0", 0, 8'h00);
        chk_reg("pinc_r1", 1, 8'h13);

        // Pair wrap on increment, then on decrement
        load(0, 8'hFF);
        load(1, 8'hFF);
        pair_mode = 1'b1; id_sel = 3'd1; idop = IDOP_INC;
        step();
        idop = IDOP_HOLD;
        chk("pwrap_inc", 32'(wrap), 32'h1);
        chk_reg("pwrap_r0", 0, 8'h00);
        chk_reg("pwrap_r1", 1, 8'h00);
        step();
        chk("pwrap_one_cycle", 32'(wrap), 32'h0);
        idop = IDOP_DEC; id_sel = 3'd0;
        step();
        idop = IDOP_HOLD; pair_mode = 1'b0;
        chk("pwrap_dec", 32'(wrap), 32'h1);
        chk_reg("pdec_r0", 0, 8'hFF);
        chk_reg("pdec_r1", 1, 8'hFF);
        step();
        chk("pdec_one_cycle", 32'(wrap), 32'h0);

        // Single-register wrap leaves its neighbour alone
        load(4, 8'hFF);
        idop = IDOP_INC; id_sel = 3'd4;
        step();
        idop = IDOP_HOLD;
        chk("swrap", 32'(wrap), 32'h1);
        chk_reg("swrap_r4", 4, 8'h00);
        chk_reg("swrap_r5", 5, 8'h00);

        // Load from mem_in beats a wrapping decrement on the same register
        load(3, 8'h00);
        ld = 1'b1; ld_sel = 3'd3; ld_src = 1'b1; mem_in = 8'h80;
        idop = IDOP_DEC; id_sel = 3'd3;
        step();
        ld = 1'b0; ld_src = 1'b0; idop = IDOP_HOLD;
        chk("ldwin_wrap", 32'(wrap), 32'h0);
        chk_reg("ldwin_r3", 3, 8'h80);

        // Load and count on different registers both land
        load(7, 8'h00);
        ld = 1'b1; ld_sel = 3'd6; data_in = 8'h11;
        idop = IDOP_INC; id_sel = 3'd7;
        step();
        ld = 1'b0; idop = IDOP_HOLD;
        chk_reg("both_r6", 6, 8'h11);
        chk_reg("both_r7", 7, 8'h01);

        // Pair mode: load low half, high half still gets the carry
        load(0, 8'hFF);
        load(1, 8'h00);
        ld = 1'b1; ld_sel = 3'd0; data_in = 8'h33;
        pair_mode = 1'b1; idop = IDOP_INC; id_sel = 3'd1;
        step();
        ld = 1'b0; idop = IDOP_HOLD; pair_mode = 1'b0;
        chk("phalf_wrap", 32'(wrap), 32'h0);
        chk_reg("phalf_r0", 0, 8'h33);
        chk_reg("phalf_r1", 1, 8'h01);

        // Memory-bus merge and contention handling
        load(0, 8'hF0);
        load(1, 8'h0F);
        drv_m = 8'h03;
        #1;
        chk("merge_mem_out", 32'(mem_out), 32'hFF);
        step();
        drv_m = '0;
        chk("cont_set", 32'(contention), 32'h1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("cont_clr", 32'(contention), 32'h0);
        clr_err = 1'b1; drv_d = 8'h06;
        step();
        clr_err = 1'b0; drv_d = '0;
        chk("cont_clr_vs_new", 32'(contention), 32'h1);

        // Asynchronous reset in the middle of a pending pair increment
        load(0, 8'hFF);
        load(1, 8'hFF);
        pair_mode = 1'b1; id_sel = 3'd0; idop = IDOP_INC;
        #2;
        rst_n = 1'b0;
        #1;
        drv_d = 8'hFF; drv_m = 8'hFF;
        #1;
        chk("arst_data_out", 32'(data_out), 32'h0);
        chk("arst_mem_out", 32'(mem_out), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        chk("arst_contention", 32'(contention), 32'h0);
        drv_d = '0; drv_m = '0;
        pair_mode = 1'b0; id_sel = 3'd5; idop = IDOP_INC;
        #1;
        rst_n = 1'b1;
        step();
        idop = IDOP_HOLD;
        chk("post_rst_wrap", 32'(wrap), 32'h0);
        chk_reg("post_rst_r5", 5, 8'h01);
        chk_reg("post_rst_r0", 0, 8'h00);
        chk_reg("post_rst_r1", 1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_datapath_regbank

// File: doc/datapath_regbank.md
DATAPATH_REGBANK -- requirements
Module: datapath_regbank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register and bus width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of registers; even, minimum 2.
REQ-003 SHALL have parameter IDXW, default 3, register index width, equal to ceil(log2(NREGS)).
REQ-004 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ld  input  1  write strobe.
REQ-007 SHALL have ld_sel  input  IDXW  register index to write.
REQ-008 SHALL have ld_src  input  1  write source: 0 selects data_in, 1 selects mem_in.
REQ-009 SHALL have data_in  input  WIDTH  data-bus write value.
REQ-010 SHALL have mem_in  input  WIDTH  memory-bus write value.
REQ-011 SHALL have idop  input  2  count operation: 00 hold, 01 increment, 10 decrement, 11 hold.
REQ-012 SHALL have id_sel  input  IDXW  target register index for idop.
REQ-013 SHALL have pair_mode  input  1  when 1, idop acts on register pair (2k,2k+1) as one 2*WIDTH value, with k = id_sel/2 and the low half at the even index.
REQ-014 SHALL have drv_d  input  NREGS  per-register data-bus drive enables.
REQ-015 SHALL have drv_m  input  NREGS  per-register memory-bus drive enables.
REQ-016 SHALL have clr_err  input  1  clears the contention flag.
REQ-017 SHALL have data_out  output  WIDTH  data-bus value.
REQ-018 SHALL have mem_out  output  WIDTH  memory-bus value.
REQ-019 SHALL have wrap  output  1  registered one-cycle pulse on count wrap-around.
REQ-020 SHALL have contention  output  1  sticky flag indicating multiple bus drivers.

Function
REQ-021 data_out SHALL be the combinational bitwise OR of all registers whose drv_d bit is set, and 0 when no bit is set; mem_out SHALL follow the same rule using drv_m.
REQ-022 A load with ld=1 SHALL write the selected source into register ld_sel on the next clock edge, with the new value visible the following cycle.
REQ-023 Increment and decrement SHALL be modulo 2^WIDTH, or modulo 2^(2*WIDTH) in pair mode, with the carry or borrow from the low half propagating into the high half in the same cycle.
REQ-024 When a load and a count operation target the same register in one cycle, the load SHALL win for that register.
REQ-025 In pair mode, a load to one half SHALL win for that half only, and the other half SHALL still receive its count result.
REQ-026 A load and a count operation on different registers in the same cycle SHALL both take effect.
REQ-027 wrap SHALL assert for exactly one cycle after a count operation moves the target from all-ones to 0 (increment) or from 0 to all-ones (decrement), using the full pair value in pair mode.
REQ-028 wrap SHALL NOT assert when a load overrides the wrapping register.
REQ-029 A load or count index of NREGS or above SHALL be ignored, with no state change and no wrap pulse.
REQ-030 contention SHALL set on the clock edge following any cycle in which drv_d or drv_m has more than one bit set.
REQ-031 contention SHALL clear on clr_err, except that when clr_err and a new contention occur in the same cycle, the flag SHALL remain set.

Reset
REQ-032 Asserting rst_n low SHALL immediately clear all registers, wrap and contention to 0, independent of clk.
REQ-033 A reset asserted mid-operation SHALL abort any pending load or count; the first edge after deassertion SHALL behave as a normal cycle.
REQ-034 Bus outputs SHALL remain combinational during reset, reflecting the zeroed registers.

Structure
REQ-035 A shared package SHALL hold the idop encodings (IDOP_HOLD, IDOP_INC, IDOP_DEC) and the index-width helper function.
REQ-036 The block SHALL be built from one sub-module, idreg_cell: a single WIDTH-bit register with load, inc/dec, carry_in/borrow_in, carry_out and an async reset, instantiated NREGS times and chained in pairs.
REQ-037 The block SHALL contain no tristate drivers; bus merging SHALL be by OR-reduction.

Verification
REQ-038 The bench SHALL cover: load reg2=0x5A from data_in, then drv_d=0x04 -> data_out=0x5A next cycle, mem_out=0x00, contention=0.
REQ-039 The bench SHALL cover: reg0=0xFF, reg1=0x12, pair_mode=1, id_sel=0, idop=inc -> reg0=0x00, reg1=0x13, wrap=0.
REQ-040 The bench SHALL cover: reg0=0xFF, reg1=0xFF, pair inc -> both 0x00, wrap=1 for exactly one cycle; then pair dec -> both 0xFF, wrap=1.
REQ-041 The bench SHALL cover: ld=1, ld_sel=3, mem_in=0x80 with idop=dec, id_sel=3 on reg3=0x00 -> reg3=0x80, wrap=0.
REQ-042 The bench SHALL cover: drv_m=0x03 with reg0=0xF0, reg1=0x0F -> mem_out=0xFF, contention=1 next cycle; clr_err alone clears it; clr_err together with drv_d=0x06 keeps it at 1.
REQ-043 The bench SHALL cover: rst_n pulsed low between clock edges during a pair increment -> all registers, wrap and contention read 0 immediately, and the first post-reset edge with idop=inc on reg5 gives reg5=0x01.
